player_motion: RTL and testbench

PLAYER_MOTION -- requirements
Module: player_motion

---
 rtl/player_motion_if.sv | 30 +++
 rtl/player_motion.sv | 245 ++++++++++++++++++++++++
 tb/tb_player_motion.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/player_motion_if.sv
// Bus between the player motion block and the map/game logic.
// The master side (map) supplies the frame tick, keys, collisions and the
// current position. The slave side (player_motion) returns the new position,
// vertical speed, player state and a one-cycle update strobe.
interface player_motion_if #(
  parameter int X_W  = 10,
  parameter int Y_W  = 9,
  parameter int VY_W = 9
);
  logic                   frame_tick;
  logic [3:0]             key;
  logic [3:0]             collision;
  logic [X_W-1:0]         current_x;
  logic [Y_W-1:0]         current_y;
  logic [X_W-1:0]         x_out;
  logic [Y_W-1:0]         y_out;
  logic signed [VY_W-1:0] vy;
  logic [2:0]             player_state;
  logic                   upd_valid;

  modport master (
    output frame_tick, key, collision, current_x, current_y,
    input  x_out, y_out, vy, player_state, upd_valid
  );

  modport slave (
    input  frame_tick, key, collision, current_x, current_y,
    output x_out, y_out, vy, player_state, upd_valid
  );
endinterface

// File: rtl/player_motion.sv
// Per-frame player motion: horizontal walking with wall stops, and a
// GROUND/RISE/FALL jump FSM with divided gravity and a terminal fall speed.
// Everything advances only on clock edges where frame_tick is high.
// Optional feature: define PLAYER_JUMP_BUFFER_EN to compile in a jump
// buffer that remembers a w press made shortly before landing.
module player_motion #(
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int VY_W     = 9,
  parameter int H_STEP   = 1,
  parameter int JUMP_V   = 6,
  parameter int MAX_FALL = 8,
  parameter int GRAV_DIV = 2,
  parameter int X_MAX    = 639,
  parameter int Y_MAX    = 479
) (
  input logic            clk,
  input logic            rst_n,
  player_motion_if.slave bus
);

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2
  } state_t;

  localparam int XE = X_W + 1;
  localparam int SW = ((Y_W > VY_W) ? Y_W : VY_W) + 2;
  localparam int CW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;

  localparam logic signed [VY_W-1:0] VY_ZERO  = {VY_W{1'b0}};
  localparam logic signed [VY_W-1:0] VY_ONE   = VY_W'(1);
  localparam logic signed [VY_W-1:0] VY_NEG1  = {VY_W{1'b1}};
  localparam logic signed [VY_W-1:0] VY_JUMP  = VY_W'(JUMP_V);
  localparam logic signed [VY_W-1:0] VY_FLOOR = VY_W'(-MAX_FALL);
  localparam logic [CW-1:0]          CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]          CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]          CNT_LAST = CW'(GRAV_DIV - 1);
  localparam logic [X_W-1:0]         X_STEP   = X_W'(H_STEP);
  localparam logic [XE-1:0]          X_STEP_E = XE'(H_STEP);
  localparam logic [XE-1:0]          X_MAX_E  = XE'(X_MAX);
  localparam logic signed [SW-1:0]   Y_MAX_S  = SW'(Y_MAX);
  localparam logic signed [SW-1:0]   Y_ZERO_S = {SW{1'b0}};

  state_t                 r_state;
  state_t                 w_state_n;
  logic signed [VY_W-1:0] r_vy;
  logic signed [VY_W-1:0] w_vy_n;
  logic signed [VY_W-1:0] w_vy_dec;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_n;
  logic [X_W-1:0]         r_x;
  logic [X_W-1:0]         w_x_n;
  logic [XE-1:0]          w_x_inc;
  logic [Y_W-1:0]         r_y;
  logic [Y_W-1:0]         w_y_n;
  logic signed [SW-1:0]   w_y_wide;
  logic [2:0]             r_pstate;
  logic                   w_face_n;
  logic                   r_upd;
  logic                   w_key_w;
  logic                   w_key_a;
  logic                   w_key_d;
  logic                   w_grav_due;
  logic                   w_land;
  logic                   w_unused;

  assign w_key_w    = bus.key[0];
  assign w_key_a    = bus.key[1];
  assign w_key_d    = bus.key[3];
  assign w_unused   = bus.key[2];
  assign w_vy_dec   = r_vy - VY_ONE;
  assign w_grav_due = (r_cnt == CNT_LAST);
  // Landing wins over an up collision, also when both hit during a rise.
  assign w_land     = bus.collision[0] &&
                      ((r_state == ST_FALL) || ((r_state == ST_RISE) && bus.collision[1]));

`ifdef PLAYER_JUMP_BUFFER_EN
  logic [1:0] r_jbuf;
  logic       r_w_prev;

  // Jump buffer: arm on a fresh w press while airborne, age once per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_jbuf   <= 2'd0;
      r_w_prev <= 1'b0;
    end else if (bus.frame_tick) begin
      r_w_prev <= w_key_w;
      if (w_land) begin
        r_jbuf <= 2'd0;
      end else if (w_key_w && !r_w_prev && (r_state != ST_GROUND)) begin
        r_jbuf <= 2'd3;
      end else if (r_jbuf != 2'd0) begin
        r_jbuf <= r_jbuf - 2'd1;
      end else begin
        r_jbuf <= r_jbuf;
      end
    end
  end
`endif

  // Jump FSM next state, vertical speed and gravity frame counter.
  always_comb begin
    w_state_n = r_state;
    w_vy_n    = r_vy;
    w_cnt_n   = r_cnt;
    if (w_land) begin
      w_cnt_n = CNT_ZERO;
`ifdef PLAYER_JUMP_BUFFER_EN
      if (r_jbuf != 2'd0) begin
        w_state_n = ST_RISE;
        w_vy_n    = VY_JUMP;
      end else begin
        w_state_n = ST_GROUND;
        w_vy_n    = VY_ZERO;
      end
`else
      w_state_n = ST_GROUND;
      w_vy_n    = VY_ZERO;
`endif
    end else begin
      case (r_state)
        ST_GROUND: begin
          w_cnt_n = CNT_ZERO;
          if (w_key_w) begin
            w_state_n = ST_RISE;
            w_vy_n    = VY_JUMP;
          end else if (!bus.collision[0]) begin
            w_state_n = ST_FALL;
            w_vy_n    = VY_ZERO;
          end else begin
            w_state_n = ST_GROUND;
            w_vy_n    = VY_ZERO;
          end
        end
        ST_RISE: begin
          if (bus.collision[1]) begin
            w_state_n = ST_FALL;
            w_vy_n    = VY_NEG1;
            w_cnt_n   = CNT_ZERO;
          end else if (w_grav_due) begin
            w_cnt_n = CNT_ZERO;
            w_vy_n  = w_vy_dec;
            if (w_vy_dec <= VY_ZERO) begin
              w_state_n = ST_FALL;
            end else begin
              w_state_n = ST_RISE;
            end
          end else begin
            w_cnt_n = r_cnt + CNT_ONE;
          end
        end
        ST_FALL: begin
          if (w_grav_due) begin
            w_cnt_n = CNT_ZERO;
            if (r_vy <= VY_FLOOR) begin
              w_vy_n = VY_FLOOR;
            end else begin
              w_vy_n = w_vy_dec;
            end
          end else begin
            w_cnt_n = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_n = ST_FALL;
          w_vy_n    = VY_ZERO;
          w_cnt_n   = CNT_ZERO;
        end
      endcase
    end
  end

  // Horizontal position and facing; a overrides d.
  always_comb begin
    w_x_n    = bus.current_x;
    w_face_n = r_pstate[0];
    w_x_inc  = {1'b0, bus.current_x} + X_STEP_E;
    if (w_key_a) begin
      w_face_n = 1'b0;
      if (bus.collision[3]) begin
        w_x_n = bus.current_x;
      end else if (bus.current_x >= X_STEP) begin
        w_x_n = bus.current_x - X_STEP;
      end else begin
        w_x_n = {X_W{1'b0}};
      end
    end else if (w_key_d) begin
      w_face_n = 1'b1;
      if (bus.collision[2]) begin
        w_x_n = bus.current_x;
      end else if (w_x_inc > X_MAX_E) begin
        w_x_n = X_MAX_E[X_W-1:0];
      end else begin
        w_x_n = w_x_inc[X_W-1:0];
      end
    end else begin
      w_x_n = bus.current_x;
    end
  end

  // Vertical position from the new speed, clamped to the screen.
  always_comb begin
    w_y_wide = $signed({{(SW-Y_W){1'b0}}, bus.current_y}) -
               $signed({{(SW-VY_W){w_vy_n[VY_W-1]}}, w_vy_n});
    if (w_y_wide < Y_ZERO_S) begin
      w_y_n = {Y_W{1'b0}};
    end else if (w_y_wide > Y_MAX_S) begin
      w_y_n = Y_MAX_S[Y_W-1:0];
    end else begin
      w_y_n = w_y_wide[Y_W-1:0];
    end
  end

  // Frame-rate state and output registers; the strobe follows every tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_FALL;
      r_vy     <= VY_ZERO;
      r_cnt    <= CNT_ZERO;
      r_x      <= {X_W{1'b0}};
      r_y      <= {Y_W{1'b0}};
      r_pstate <= 3'b010;
      r_upd    <= 1'b0;
    end else begin
      r_upd <= bus.frame_tick;
      if (bus.frame_tick) begin
        r_state  <= w_state_n;
        r_vy     <= w_vy_n;
        r_cnt    <= w_cnt_n;
        r_x      <= w_x_n;
        r_y      <= w_y_n;
        r_pstate <= {(w_key_a | w_key_d), (w_state_n != ST_GROUND), w_face_n};
      end
    end
  end

  assign bus.x_out        = r_x;
  assign bus.y_out        = r_y;
  assign bus.vy           = r_vy;
  assign bus.player_state = r_pstate;
  assign bus.upd_valid    = r_upd;

endmodule

// File: tb/tb_player_motion.sv
// Self-checking bench for player_motion: directed scenarios followed by a
// randomized run, all compared against a frame-level behavioural model.
// Define PLAYER_JUMP_BUFFER_EN to build the bench for the buffered variant.
module tb_player_motion;
  localparam int X_W = 10, Y_W = 9, VY_W = 9;
  localparam int H_STEP = 1, JUMP_V = 6, MAX_FALL = 8, GRAV_DIV = 2;
  localparam int X_MAX = 639, Y_MAX = 479;
`ifdef PLAYER_JUMP_BUFFER_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  player_motion_if #(.X_W(X_W), .Y_W(Y_W), .VY_W(VY_W)) bus_if ();

  player_motion #(
    .X_W(X_W), .Y_W(Y_W), .VY_W(VY_W), .H_STEP(H_STEP), .JUMP_V(JUMP_V),
    .MAX_FALL(MAX_FALL), .GRAV_DIV(GRAV_DIV), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: airborne/rising flags, speed, frames since last gravity step.
  bit m_air, m_rise, m_face, m_prev_w;
  int m_vy, m_frames, m_buf;
  int e_x, e_y, e_vy, e_ps;
  int cy_saved;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_air = 1'b1; m_rise = 1'b0; m_face = 1'b0; m_prev_w = 1'b0;
    m_vy = 0; m_frames = 0; m_buf = 0;
    e_x = 0; e_y = 0; e_vy = 0; e_ps = 2;
  endtask

  task automatic model_step(input bit w, input bit a, input bit d, input bit [3:0] c,
                            input int cx, input int cy);
    bit land;
    int old_buf;
    int ny;
    land    = m_air && c[0] && (!m_rise || c[1]);
    old_buf = m_buf;
    if (BUF_EN) begin
      if (land) m_buf = 0;
      else if (w && !m_prev_w && m_air) m_buf = 3;
      else if (m_buf > 0) m_buf = m_buf - 1;
    end
    m_prev_w = w;
    if (!m_air) begin
      if (w) begin m_air = 1; m_rise = 1; m_vy = JUMP_V; m_frames = 0; end
      else if (!c[0]) begin m_air = 1; m_rise = 0; m_vy = 0; m_frames = 0; end
      else m_vy = 0;
    end else if (land) begin
      m_frames = 0;
      if (old_buf > 0) begin m_rise = 1; m_vy = JUMP_V; end
      else begin m_air = 0; m_rise = 0; m_vy = 0; end
    end else if (m_rise && c[1]) begin
      m_rise = 0; m_vy = -1; m_frames = 0;
    end else begin
      m_frames++;
      if (m_frames == GRAV_DIV) begin
        m_frames = 0;
        m_vy = m_vy - 1;
        if (m_rise && m_vy <= 0) m_rise = 0;
        if (!m_rise && m_vy < -MAX_FALL) m_vy = -MAX_FALL;
      end
    end
    if (a) begin
      m_face = 0;
      e_x = c[3] ? cx : ((cx - H_STEP < 0) ? 0 : cx - H_STEP);
    end else if (d) begin
      m_face = 1;
      e_x = c[2] ? cx : ((cx + H_STEP > X_MAX) ? X_MAX : cx + H_STEP);
    end else begin
      e_x = cx;
    end
    ny = cy - m_vy;
    e_y  = (ny < 0) ? 0 : ((ny > Y_MAX) ? Y_MAX : ny);
    e_vy = m_vy;
    e_ps = ((a || d) ? 4 : 0) + (m_air ? 2 : 0) + (m_face ? 1 : 0);
  endtask

  task automatic check_all(input string tag, input int upd);
    chk({tag, "_x"},   32'(bus_if.x_out), e_x);
    chk({tag, "_y"},   32'(bus_if.y_out), e_y);
    chk({tag, "_vy"},  32'(bus_if.vy), e_vy);
    chk({tag, "_ps"},  32'(bus_if.player_state), e_ps);
    chk({tag, "_upd"}, 32'(bus_if.upd_valid), upd);
  endtask

  // One frame: tick, check the update, then one non-tick cycle with noise.
  task automatic tick(input string tag, input bit w, input bit a, input bit d,
                      input bit [3:0] c, input int cx, input int cy);
    @(negedge clk);
    bus_if.key        = {d, 1'b0, a, w};
    bus_if.collision  = c;
    bus_if.current_x  = X_W'(cx);
    bus_if.current_y  = Y_W'(cy);
    bus_if.frame_tick = 1'b1;
    @(posedge clk);
    model_step(w, a, d, c, cx, cy);
    @(negedge clk);
    bus_if.frame_tick = 1'b0;
    check_all(tag, 1);
    bus_if.key       = 4'($urandom);
    bus_if.collision = 4'($urandom);
    bus_if.current_x = X_W'($urandom);
    bus_if.current_y = Y_W'($urandom);
    @(negedge clk);
    check_all({tag, "_hold"}, 0);
  endtask

  initial begin
    bit w, a, d;
    bit [3:0] c;
    int cx, cy, sel;

    rst_n = 1'b0;
    bus_if.frame_tick = 1'b0;
    bus_if.key = 4'd0;
    bus_if.collision = 4'd0;
    bus_if.current_x = '0;
    bus_if.current_y = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset", 0);
    rst_n = 1'b1;

    // Land, then jump from y=300.
    tick("settle", 0, 0, 0, 4'b0001, 100, 300);
    chk("settle_ground", 32'(bus_if.player_state[1]), 0);
    tick("jump", 1, 0, 0, 4'b0001, 100, 300);
    chk("jump_vy", 32'(bus_if.vy), 6);
    chk("jump_y", 32'(bus_if.y_out), 294);
    chk("jump_air", 32'(bus_if.player_state[1]), 1);

    // Rise four frames to reach vy=4, then hit the ceiling.
    for (int i = 0; i < 4; i++) tick("rise", 0, 0, 0, 4'b0000, 100, e_y);
    chk("ceil_pre_vy", 32'(bus_if.vy), 4);
    cy_saved = e_y;
    tick("ceil", 0, 0, 0, 4'b0010, 100, cy_saved);
    chk("ceil_vy", 32'(bus_if.vy), -1);
    chk("ceil_y", 32'(bus_if.y_out), cy_saved + 1);

    // Long fall: gravity every second frame down to terminal speed.
    for (int i = 0; i < 40; i++) tick("fall", 0, 0, 0, 4'b0000, 200, 100);
    chk("fall_clamp", 32'(bus_if.vy), -8);

    // Land and press both a and d at the left edge.
    tick("land", 0, 0, 0, 4'b0001, 200, 300);
    tick("ad_edge", 0, 1, 1, 4'b0001, 0, 300);
    chk("ad_x", 32'(bus_if.x_out), 0);
    chk("ad_face", 32'(bus_if.player_state[0]), 0);
    chk("ad_walk", 32'(bus_if.player_state[2]), 1);

    // Walk off a ledge, press w two frames before touching down.
    tick("ledge", 0, 0, 0, 4'b0000, 50, 200);
    tick("wpress", 1, 0, 0, 4'b0000, 50, e_y);
    tick("wrel", 0, 0, 0, 4'b0000, 50, e_y);
    tick("touch", 0, 0, 0, 4'b0001, 50, e_y);
    chk("buf_vy", 32'(bus_if.vy), BUF_EN ? 6 : 0);
    chk("buf_air", 32'(bus_if.player_state[1]), BUF_EN ? 1 : 0);
    tick("reground", 0, 0, 0, 4'b0001, 50, 200);

    // Reset between ticks in the middle of a jump.
    tick("jump2", 1, 0, 1, 4'b0001, 300, 250);
    tick("rise2", 0, 0, 0, 4'b0000, 300, e_y);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst", 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick("postrst", 0, 0, 0, 4'b0000, 120, 200);
    chk("postrst_vy", 32'(bus_if.vy), 0);
    chk("postrst_air", 32'(bus_if.player_state[1]), 1);

    // Randomized play with edge-biased positions.
    for (int i = 0; i < 300; i++) begin
      w = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 2) == 0);
      c = 4'($urandom);
      c[0] = ($urandom_range(0, 2) == 0);
      if (a && d) c[3] = 1'b0;
      sel = $urandom_range(0, 5);
      cx = (sel == 0) ? 0 : (sel == 1) ? X_MAX : (sel == 2) ? $urandom_range(0, X_MAX) : e_x;
      sel = $urandom_range(0, 5);
      cy = (sel == 0) ? $urandom_range(0, 3) : (sel == 1) ? $urandom_range(Y_MAX - 3, Y_MAX) :
           (sel == 2) ? $urandom_range(0, Y_MAX) : e_y;
      tick("rand", w, a, d, c, cx, cy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
